// File: rtl/serial_tx_pkg.sv
// Shared serial-link constants, baud helpers and transmitter state encoding.
// Also used by the companion receiver.
package serial_tx_pkg;

   localparam int unsigned ClkHz       = 12_000_000;
   localparam int unsigned BaudDefault = 250_000;
   localparam int unsigned FrameBits   = 10;

   // Clocks per bit, rounded to nearest.
   function automatic int unsigned baud_divisor(input int unsigned clk_hz,
                                                input int unsigned baud);
      return (clk_hz + baud / 2) / baud;
   endfunction

   localparam int unsigned DivisorDefault = baud_divisor(ClkHz, BaudDefault);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop,
      StGap
   } tx_state_e;

endpackage

// File: rtl/serial_tx_if.sv
// Parallel write side of the serial transmitter: byte, strobe and FIFO status.
interface serial_tx_if;

   logic [7:0] parallel_in;
   logic       parallel_in_strobe;
   logic       fifo_full;
   logic       overflow;

   modport master (
      output parallel_in,
      output parallel_in_strobe,
      input  fifo_full,
      input  overflow
   );

   modport slave (
      input  parallel_in,
      input  parallel_in_strobe,
      output fifo_full,
      output overflow
   );

endinterface

// File: rtl/serial_tx_fifo.sv
// Synchronous FIFO with registered count and full flag; pushes while full are ignored.
module serial_tx_fifo #(
   parameter int unsigned ADDR_BITS = 2,
   parameter int unsigned WIDTH     = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 push_i,
   input  logic [WIDTH-1:0]     din_i,
   input  logic                 pop_i,
   output logic [WIDTH-1:0]     dout_o,
   output logic [ADDR_BITS:0]   count_o,
   output logic                 full_o,
   output logic                 empty_o
);

   localparam int unsigned Depth = 2 ** ADDR_BITS;

   logic [WIDTH-1:0]     mem_q [Depth];
   logic [WIDTH-1:0]     mem_d [Depth];
   logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_BITS:0]   count_q, count_d;
   logic                 full_q, full_d;
   logic                 do_push, do_pop;

   // Full is judged on the registered flag, so a same-cycle pop never makes room.
   assign do_push = push_i & ~full_q;
   assign do_pop  = pop_i & (count_q != '0);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = din_i;
         wr_ptr_d        = wr_ptr_q + ADDR_BITS'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + ADDR_BITS'(1);
      end
      count_d = count_q + (ADDR_BITS + 1)'(do_push) - (ADDR_BITS + 1)'(do_pop);
      full_d  = (count_d == (ADDR_BITS + 1)'(Depth));
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign dout_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign full_o  = full_q;
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/serial_tx.sv
// 8-N-1 serial transmitter: FIFO-buffered bytes shifted out LSB-first with
// start bit, stop bit and an optional idle gap between frames.
module serial_tx
   import serial_tx_pkg::*;
#(
   parameter int unsigned DIVISOR        = DivisorDefault,
   parameter int unsigned DIVISOR_BITS   = 6,
   parameter int unsigned FIFO_ADDR_BITS = 2,
   parameter int unsigned GAP_BITS       = 0
) (
   input  logic        clk,
   input  logic        reset,
   serial_tx_if.slave  bus,
   output logic        busy,
   output logic        serial_out
);

   localparam logic [DIVISOR_BITS-1:0] TimerLast = DIVISOR_BITS'(DIVISOR - 1);
   localparam logic [3:0]              GapLast   = 4'(GAP_BITS == 0 ? 0 : GAP_BITS - 1);

   tx_state_e               state_q, state_d;
   logic [DIVISOR_BITS-1:0] timer_q, timer_d;
   logic [2:0]              bit_idx_q, bit_idx_d;
   logic [3:0]              gap_cnt_q, gap_cnt_d;
   logic [7:0]              shift_q, shift_d;
   logic                    serial_q, serial_d;
   logic                    overflow_q, overflow_d;

   logic                    pop;
   logic                    bit_end;
   logic                    frame_end;
   logic [7:0]              fifo_dout;
   logic [FIFO_ADDR_BITS:0] fifo_count;
   logic                    fifo_full;
   logic                    fifo_empty;

   serial_tx_fifo #(
      .ADDR_BITS (FIFO_ADDR_BITS),
      .WIDTH     (8)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (bus.parallel_in_strobe),
      .din_i   (bus.parallel_in),
      .pop_i   (pop),
      .dout_o  (fifo_dout),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign bit_end = (timer_q == TimerLast);

   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      bit_idx_d  = bit_idx_q;
      gap_cnt_d  = gap_cnt_q;
      shift_d    = shift_q;
      serial_d   = serial_q;
      overflow_d = overflow_q | (bus.parallel_in_strobe & fifo_full);
      pop        = 1'b0;
      frame_end  = 1'b0;

      if (state_q != StIdle) begin
         timer_d = bit_end ? '0 : timer_q + DIVISOR_BITS'(1);
      end

      unique case (state_q)
         StIdle: begin
            if (!fifo_empty) begin
               pop      = 1'b1;
               shift_d  = fifo_dout;
               serial_d = 1'b0;
               timer_d  = '0;
               state_d  = StStart;
            end
         end
         StStart: begin
            if (bit_end) begin
               bit_idx_d = '0;
               serial_d  = shift_q[0];
               state_d   = StData;
            end
         end
         StData: begin
            if (bit_end) begin
               if (bit_idx_q == 3'd7) begin
                  serial_d = 1'b1;
                  state_d  = StStop;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  serial_d  = shift_q[bit_idx_d];
               end
            end
         end
         StStop: begin
            if (bit_end) begin
               if (GAP_BITS != 0) begin
                  gap_cnt_d = '0;
                  state_d   = StGap;
               end else begin
                  frame_end = 1'b1;
               end
            end
         end
         StGap: begin
            if (bit_end) begin
               if (gap_cnt_q == GapLast) begin
                  frame_end = 1'b1;
               end else begin
                  gap_cnt_d = gap_cnt_q + 4'd1;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Chain straight into the next start bit so back-to-back frames have no slack.
      if (frame_end) begin
         if (!fifo_empty) begin
            pop      = 1'b1;
            shift_d  = fifo_dout;
            serial_d = 1'b0;
            state_d  = StStart;
         end else begin
            serial_d = 1'b1;
            state_d  = StIdle;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= StIdle;
         timer_q    <= '0;
         bit_idx_q  <= '0;
         gap_cnt_q  <= '0;
         shift_q    <= '0;
         serial_q   <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         bit_idx_q  <= bit_idx_d;
         gap_cnt_q  <= gap_cnt_d;
         shift_q    <= shift_d;
         serial_q   <= serial_d;
         overflow_q <= overflow_d;
      end
   end

   assign busy          = (state_q != StIdle) || (fifo_count != '0);
   assign serial_out    = serial_q;
   assign bus.fifo_full = fifo_full;
   assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_serial_tx.sv
// Directed and random bench for serial_tx with a behavioural line receiver per DUT.
module tb_serial_tx;

   localparam int unsigned Div = 48;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_tx_if bus0 ();
   serial_tx_if bus2 ();
   logic busy0, so0, busy2, so2;

   serial_tx #(
      .DIVISOR        (Div),
      .DIVISOR_BITS   (6),
      .FIFO_ADDR_BITS (2),
      .GAP_BITS       (0)
   ) dut0 (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus0),
      .busy       (busy0),
      .serial_out (so0)
   );

   serial_tx #(
      .DIVISOR        (Div),
      .DIVISOR_BITS   (6),
      .FIFO_ADDR_BITS (2),
      .GAP_BITS       (2)
   ) dut2 (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus2),
      .busy       (busy2),
      .serial_out (so2)
   );

   // Received frames: byte, start-edge cycle, framing good.
   logic [7:0] rx0_b[$], rx2_b[$], exp0[$];
   int         rx0_s[$], rx2_s[$];
   logic       rx0_ok[$], rx2_ok[$];

   task automatic check(input string tag, input int got, input int exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic line(input int which);
      return (which == 0) ? so0 : so2;
   endfunction

   // Receiver model: detect the falling edge, then sample mid-bit.
   task automatic monitor(input int which);
      logic prev, ln, ok;
      logic [7:0] d;
      int s;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         ln = line(which);
         if (prev && !ln) begin
            s  = cyc;
            ok = 1'b1;
            d  = '0;
            repeat (Div / 2 - 1) @(negedge clk);
            ok &= ~line(which);
            for (int i = 0; i < 8; i++) begin
               repeat (Div) @(negedge clk);
               d[i] = line(which);
            end
            repeat (Div) @(negedge clk);
            ok &= line(which);
            if (which == 0) begin
               rx0_b.push_back(d); rx0_s.push_back(s); rx0_ok.push_back(ok);
            end else begin
               rx2_b.push_back(d); rx2_s.push_back(s); rx2_ok.push_back(ok);
            end
            ln = 1'b1;
         end
         prev = ln;
      end
   endtask

   initial monitor(0);
   initial monitor(2);

   task automatic push0(input logic [7:0] b);
      bus0.parallel_in        = b;
      bus0.parallel_in_strobe = 1'b1;
      @(negedge clk);
   endtask

   task automatic push2(input logic [7:0] b);
      bus2.parallel_in        = b;
      bus2.parallel_in_strobe = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_idle(input int which, input int budget);
      int k;
      k = 0;
      while (((which == 0) ? busy0 : busy2) && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("idle_timeout", int'(k < budget), 1);
   endtask

   task automatic check_rx0();
      check("rx0_count", rx0_b.size(), exp0.size());
      for (int i = 0; i < rx0_b.size() && i < exp0.size(); i++) begin
         check("rx0_byte", rx0_b[i], exp0[i]);
         check("rx0_framing", rx0_ok[i], 1);
      end
      rx0_b.delete(); rx0_s.delete(); rx0_ok.delete(); exp0.delete();
   endtask

   initial begin
      int n, werr, first_bad, nb, sent;
      logic [9:0] frame;
      logic [7:0] b;

      bus0.parallel_in = '0; bus0.parallel_in_strobe = 1'b0;
      bus2.parallel_in = '0; bus2.parallel_in_strobe = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_serial_out", so0, 1);
      check("rst_fifo_full", bus0.fifo_full, 0);
      check("rst_overflow", bus0.overflow, 0);
      check("rst_busy", busy0, 0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // Single 0xA5: exact waveform and busy window, cycle by cycle.
      frame = {1'b1, 8'hA5, 1'b0};
      n = cyc; werr = 0; first_bad = -1;
      bus0.parallel_in = 8'hA5; bus0.parallel_in_strobe = 1'b1;
      for (int t = 0; t < 490; t++) begin
         if (t == 1) bus0.parallel_in_strobe = 1'b0;
         if (so0 !== ((t >= 2 && t < 482) ? frame[(t - 2) / Div] : 1'b1) ||
             busy0 !== (t >= 1 && t < 482)) begin
            werr++;
            if (first_bad < 0) first_bad = t;
         end
         @(negedge clk);
      end
      check("a5_wave_errors", werr, 0);
      check("a5_first_bad_cycle", first_bad, -1);
      check("a5_start_cycle", (rx0_s.size() > 0) ? rx0_s[0] - n : -1, 2);
      exp0.push_back(8'hA5);
      check_rx0();

      // Three bytes back-to-back: start bits 480 cycles apart.
      push0(8'h00); push0(8'hFF); push0(8'h55);
      bus0.parallel_in_strobe = 1'b0;
      wait_idle(0, 3 * 480 + 50);
      check("b2b_overflow", bus0.overflow, 0);
      check("b2b_gap01", (rx0_s.size() > 1) ? rx0_s[1] - rx0_s[0] : -1, 480);
      check("b2b_gap12", (rx0_s.size() > 2) ? rx0_s[2] - rx0_s[1] : -1, 480);
      exp0.push_back(8'h00); exp0.push_back(8'hFF); exp0.push_back(8'h55);
      check_rx0();

      // Six strobes: the sixth hits a full FIFO and is dropped.
      n = cyc;
      for (int i = 0; i < 6; i++) begin
         b = 8'($urandom);
         if (i < 5) exp0.push_back(b);
         bus0.parallel_in = b; bus0.parallel_in_strobe = 1'b1;
         if (i == 4) check("ovf_full_before", bus0.fifo_full, 0);
         if (i == 5) begin
            check("ovf_full_at_6th", bus0.fifo_full, 1);
            check("ovf_before", bus0.overflow, 0);
         end
         @(negedge clk);
      end
      bus0.parallel_in_strobe = 1'b0;
      check("ovf_after", bus0.overflow, 1);
      while (cyc < n + 481) @(negedge clk);
      check("full_before_pop", bus0.fifo_full, 1);
      @(negedge clk);
      check("full_after_pop", bus0.fifo_full, 0);
      wait_idle(0, 5 * 480 + 50);
      check("ovf_sticky", bus0.overflow, 1);
      check_rx0();
      reset = 1'b0; @(negedge clk); reset = 1'b1;
      check("ovf_cleared", bus0.overflow, 0);
      @(negedge clk);

      // GAP_BITS=2: frames 576 cycles apart.
      push2(8'h81); push2(8'h7E);
      bus2.parallel_in_strobe = 1'b0;
      wait_idle(2, 2 * 576 + 50);
      check("gap_count", rx2_b.size(), 2);
      check("gap_spacing", (rx2_s.size() > 1) ? rx2_s[1] - rx2_s[0] : -1, 576);
      check("gap_byte0", (rx2_b.size() > 0) ? rx2_b[0] : -1, 8'h81);
      check("gap_byte1", (rx2_b.size() > 1) ? rx2_b[1] : -1, 8'h7E);

      // Reset mid-DATA of 0x3C with two more queued.
      n = cyc;
      push0(8'h3C); push0(8'hAA); push0(8'h55);
      bus0.parallel_in_strobe = 1'b0;
      while (cyc < n + 2 + Div * 4 + 10) @(negedge clk);
      reset = 1'b0; @(negedge clk); reset = 1'b1;
      check("midrst_serial_out", so0, 1);
      check("midrst_busy", busy0, 0);
      check("midrst_full", bus0.fifo_full, 0);
      check("midrst_overflow", bus0.overflow, 0);
      repeat (1100) @(negedge clk);
      check("midrst_frames", rx0_s.size(), 1);
      check("midrst_line_idle", so0, 1);
      rx0_b.delete(); rx0_s.delete(); rx0_ok.delete();

      // Random bursts looped back through the receiver model.
      sent = 0;
      while (sent < 48) begin
         nb = $urandom_range(1, 5);
         for (int i = 0; i < nb; i++) begin
            b = 8'($urandom);
            exp0.push_back(b);
            push0(b);
         end
         bus0.parallel_in_strobe = 1'b0;
         sent += nb;
         wait_idle(0, 5 * 480 + 50);
         repeat ($urandom_range(0, 7)) @(negedge clk);
      end
      check("rand_overflow", bus0.overflow, 0);
      check_rx0();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
